vec_chunk_server: RTL and testbench

VEC_CHUNK_SERVER -- requirements
Module: vec_chunk_server

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_slot_buf.sv | 48 ++++
 rtl/vec_chunk_server.sv | 129 ++++++++++++
 tb/tb_vec_chunk_server.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector chunk server.
// Latency: n/a (package only).
// Backpressure: n/a.
package vec_pkg;

  // Default element width and its signed element type.
  localparam int unsigned ELEM_BITS = 8;
  typedef logic signed [ELEM_BITS-1:0] elem_t;

  // Bit positions inside err_flags.
  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;

  // Integer ceiling division, used to size the chunk index.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/vec_slot_buf.sv
// Two-slot vector store with a whole-vector write port and a chunk-select read port.
// Latency: write lands on the next edge; read path is combinational.
// Backpressure: none here; the owner decides when writes are legal.
module vec_slot_buf
  import vec_pkg::*;
#(
  parameter int unsigned InVecLength = 11,
  parameter int unsigned ChunkElems  = 11,
  parameter int unsigned NBits       = 8,
  parameter int unsigned CiW         = 1
) (
  input  logic                                clk_in,
  input  logic                                wr_en_i,
  input  logic                                wr_sel_i,
  input  logic [InVecLength-1:0][NBits-1:0]   wr_data_i,
  input  logic                                rd_sel_i,
  input  logic [CiW-1:0]                      rd_ci_i,
  output logic [ChunkElems-1:0][NBits-1:0]    rd_chunk_o
);

  localparam int unsigned NChunks   = ceil_div(InVecLength, ChunkElems);
  localparam int unsigned VecBits   = InVecLength * NBits;
  localparam int unsigned ChunkBits = ChunkElems * NBits;
  localparam int unsigned PadBits   = NChunks * ChunkBits;

  logic [InVecLength-1:0][NBits-1:0] slot_q [2];
  logic [PadBits-1:0]                padded;

  // Capture a full vector into the addressed slot; contents survive reset on purpose.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      slot_q[wr_sel_i] <= wr_data_i;
    end
  end

  // Zero-extend the selected slot to a whole number of chunks, then mux out chunk ci.
  always_comb begin
    padded              = '0;
    padded[VecBits-1:0] = slot_q[rd_sel_i];
    rd_chunk_o          = '0;
    for (int c = 0; c < int'(NChunks); c++) begin
      if (rd_ci_i == CiW'(c)) begin
        rd_chunk_o = padded[c*ChunkBits +: ChunkBits];
      end
    end
  end

endmodule

// File: rtl/vec_chunk_server.sv
// Ping-pong vector buffer that serves each stored vector as a sequence of fixed-size chunks.
// Latency: a served request produces chunk_valid exactly one cycle later.
// Backpressure: in_ready drops when both slots are full; writes then are dropped and flagged.
module vec_chunk_server
  import vec_pkg::*;
#(
  parameter int unsigned InVecLength = 11,
  parameter int unsigned ChunkElems  = 11,
  parameter int unsigned NBits       = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               in_data_ready,
  input  logic [InVecLength-1:0][NBits-1:0]  in_data,
  output logic                               in_ready,
  input  logic                               req_chunk_in,
  output logic [ChunkElems-1:0][NBits-1:0]   chunk_data,
  output logic                               chunk_valid,
  output logic                               chunk_last,
  output logic                               vec_avail,
  output logic [1:0]                         err_flags
);

  localparam int unsigned    NChunks = ceil_div(InVecLength, ChunkElems);
  localparam int unsigned    CiW     = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam logic [CiW-1:0] CiLast  = CiW'(NChunks - 1);

  logic [1:0]                       count_q, count_d;
  logic                             wp_q, wp_d;
  logic                             rp_q, rp_d;
  logic [CiW-1:0]                   ci_q, ci_d;
  logic [ChunkElems-1:0][NBits-1:0] chunk_data_q, chunk_data_d;
  logic                             chunk_valid_q, chunk_valid_d;
  logic                             chunk_last_q, chunk_last_d;
  logic [1:0]                       err_q, err_d;
  logic [ChunkElems-1:0][NBits-1:0] buf_chunk;
  logic                             wr_acc, rd_srv, rd_last;

  // Ready/available come from the registered count only, never from same-cycle reads.
  assign in_ready  = (count_q < 2'd2);
  assign vec_avail = (count_q != 2'd0);
  assign wr_acc    = in_data_ready && in_ready;
  assign rd_srv    = req_chunk_in && vec_avail;
  assign rd_last   = rd_srv && (ci_q == CiLast);

  vec_slot_buf #(
    .InVecLength (InVecLength),
    .ChunkElems  (ChunkElems),
    .NBits       (NBits),
    .CiW         (CiW)
  ) u_slot_buf (
    .clk_in      (clk_in),
    .wr_en_i     (wr_acc),
    .wr_sel_i    (wp_q),
    .wr_data_i   (in_data),
    .rd_sel_i    (rp_q),
    .rd_ci_i     (ci_q),
    .rd_chunk_o  (buf_chunk)
  );

  // Next-state: pointer/count/chunk-index bookkeeping, output chunk capture, sticky errors.
  always_comb begin
    count_d       = count_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    ci_d          = ci_q;
    chunk_data_d  = chunk_data_q;
    chunk_valid_d = rd_srv;
    chunk_last_d  = rd_last;
    err_d         = err_q;

    if (wr_acc) begin
      wp_d = ~wp_q;
    end

    if (rd_srv) begin
      chunk_data_d = buf_chunk;
      if (rd_last) begin
        ci_d = '0;
        rp_d = ~rp_q;
      end else begin
        ci_d = ci_q + 1'b1;
      end
    end

    // A write and a vector retirement in the same edge cancel out.
    case ({wr_acc, rd_last})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (in_data_ready && !in_ready) begin
      err_d[ERR_OVF] = 1'b1;
    end
    if (req_chunk_in && !vec_avail) begin
      err_d[ERR_UNF] = 1'b1;
    end
  end

  // State register with synchronous reset; any partially served vector is discarded.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q       <= 2'd0;
      wp_q          <= 1'b0;
      rp_q          <= 1'b0;
      ci_q          <= '0;
      chunk_data_q  <= '0;
      chunk_valid_q <= 1'b0;
      chunk_last_q  <= 1'b0;
      err_q         <= 2'b00;
    end else begin
      count_q       <= count_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      ci_q          <= ci_d;
      chunk_data_q  <= chunk_data_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_last_q  <= chunk_last_d;
      err_q         <= err_d;
    end
  end

  assign chunk_data  = chunk_data_q;
  assign chunk_valid = chunk_valid_q;
  assign chunk_last  = chunk_last_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_vec_chunk_server.sv
// Bench for vec_chunk_server: two instances (12/4 and 11/4), scoreboard-checked chunk stream.
// Expected chunks are pushed at request time; a negedge monitor pops and compares.
// Status outputs (ready, avail, errors) are checked directly at fixed points.
module tb_vec_chunk_server;
  import vec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: 12 elements, 4 per chunk (exact multiple).
  logic              a_wr, a_req, a_rdy, a_vld, a_last, a_avail;
  logic [11:0][7:0]  a_dat;
  logic [3:0][7:0]   a_chunk;
  logic [1:0]        a_err;

  // Instance B: 11 elements, 4 per chunk (last chunk padded).
  logic              b_wr, b_req, b_rdy, b_vld, b_last, b_avail;
  logic [10:0][7:0]  b_dat;
  logic [3:0][7:0]   b_chunk;
  logic [1:0]        b_err;

  vec_chunk_server #(.InVecLength(12), .ChunkElems(4), .NBits(8)) u_dut_a (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_data_ready (a_wr),
    .in_data       (a_dat),
    .in_ready      (a_rdy),
    .req_chunk_in  (a_req),
    .chunk_data    (a_chunk),
    .chunk_valid   (a_vld),
    .chunk_last    (a_last),
    .vec_avail     (a_avail),
    .err_flags     (a_err)
  );

  vec_chunk_server #(.InVecLength(11), .ChunkElems(4), .NBits(8)) u_dut_b (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_data_ready (b_wr),
    .in_data       (b_dat),
    .in_ready      (b_rdy),
    .req_chunk_in  (b_req),
    .chunk_data    (b_chunk),
    .chunk_valid   (b_vld),
    .chunk_last    (b_last),
    .vec_avail     (b_avail),
    .err_flags     (b_err)
  );

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected chunk appears one cycle after the edge that samples the request.
  task automatic push_a(input logic [31:0] d, input logic l);
    exp_t e;
    e.dat = d; e.last = l; e.cyc = cyc + 1;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] d, input logic l);
    exp_t e;
    e.dat = d; e.last = l; e.cyc = cyc + 1;
    qb.push_back(e);
  endtask

  task automatic set_b(input int base);
    for (int i = 0; i < 11; i++) b_dat[i] = 8'(base + i);
  endtask

  // Monitor: every chunk_valid must match the head of the scoreboard, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (a_vld) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL chunkA_unexpected: got dat=%h last=%0b at cyc=%0d, want no chunk", a_chunk, a_last, cyc);
      end else begin
        e = qa.pop_front();
        if (a_chunk !== e.dat || a_last !== e.last || cyc != e.cyc) begin
          bad++;
          $display("FAIL chunkA: got dat=%h last=%0b cyc=%0d, want dat=%h last=%0b cyc=%0d",
                   a_chunk, a_last, cyc, e.dat, e.last, e.cyc);
        end
      end
    end
    if (b_vld) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL chunkB_unexpected: got dat=%h last=%0b at cyc=%0d, want no chunk", b_chunk, b_last, cyc);
      end else begin
        e = qb.pop_front();
        if (b_chunk !== e.dat || b_last !== e.last || cyc != e.cyc) begin
          bad++;
          $display("FAIL chunkB: got dat=%h last=%0b cyc=%0d, want dat=%h last=%0b cyc=%0d",
                   b_chunk, b_last, cyc, e.dat, e.last, e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_wr = 1'b0; a_req = 1'b0; a_dat = '0;
    b_wr = 1'b0; b_req = 1'b0; b_dat = '0;
    tick();
    tick();

    // Reset state.
    chk("rst_a_ready",  a_rdy,   1);
    chk("rst_b_ready",  b_rdy,   1);
    chk("rst_b_avail",  b_avail, 0);
    chk("rst_b_err",    b_err,   0);
    chk("rst_b_valid",  b_vld,   0);
    chk("rst_b_chunk",  b_chunk, 0);
    rst = 1'b0;
    tick();

    // 12/4: three exact chunks, last only on the third.
    for (int i = 0; i < 12; i++) a_dat[i] = 8'(i);
    a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    chk("a_avail_after_wr", a_avail, 1);
    a_req = 1'b1;
    push_a(32'h03020100, 1'b0); tick();
    push_a(32'h07060504, 1'b0); tick();
    push_a(32'h0B0A0908, 1'b1); tick();
    a_req = 1'b0;
    chk("a_avail_drained", a_avail, 0);
    tick();

    // Underflow at idle, then cleared by a one-cycle reset.
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    chk("unf_no_valid", b_vld, 0);
    chk("unf_err",      b_err, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unf_err_cleared", b_err, 0);

    // 11/4: final chunk has a zero lane.
    set_b(1);
    b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    b_req = 1'b1;
    push_b(32'h04030201, 1'b0); tick();
    push_b(32'h08070605, 1'b0); tick();
    push_b(32'h000B0A09, 1'b1); tick();
    b_req = 1'b0;
    tick();

    // Fill both slots, third write dropped with overflow; drain A then B.
    set_b(16);
    b_wr = 1'b1;
    tick();
    set_b(32);
    tick();
    chk("full_not_ready", b_rdy, 0);
    set_b(48);
    tick();
    b_wr = 1'b0;
    chk("ovf_err",      b_err,   2'b01);
    chk("full_avail",   b_avail, 1);
    b_req = 1'b1;
    push_b(32'h13121110, 1'b0); tick();
    push_b(32'h17161514, 1'b0); tick();
    push_b(32'h001A1918, 1'b1); tick();
    push_b(32'h23222120, 1'b0); tick();
    push_b(32'h27262524, 1'b0); tick();
    push_b(32'h002A2928, 1'b1); tick();
    b_req = 1'b0;
    chk("drain_avail", b_avail, 0);
    chk("drain_ready", b_rdy,   1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Final-chunk read and write in the same cycle at count 1.
    set_b(64);
    b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    b_req = 1'b1;
    push_b(32'h43424140, 1'b0); tick();
    push_b(32'h47464544, 1'b0); tick();
    set_b(80);
    b_wr = 1'b1;
    push_b(32'h004A4948, 1'b1); tick();
    b_wr = 1'b0;
    b_req = 1'b0;
    chk("swap_avail", b_avail, 1);
    chk("swap_ready", b_rdy,   1);
    b_req = 1'b1;
    push_b(32'h53525150, 1'b0); tick();
    push_b(32'h57565554, 1'b0); tick();
    push_b(32'h005A5958, 1'b1); tick();
    b_req = 1'b0;
    chk("swap_drained", b_avail, 0);
    chk("swap_err",     b_err,   0);

    // Reset after the first of three chunks; a fresh vector restarts at chunk 0.
    set_b(96);
    b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    b_req = 1'b1;
    push_b(32'h63626160, 1'b0); tick();
    b_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_avail", b_avail, 0);
    chk("midrst_ready", b_rdy,   1);
    chk("midrst_valid", b_vld,   0);
    set_b(112);
    b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    b_req = 1'b1;
    push_b(32'h73727170, 1'b0); tick();
    b_req = 1'b0;
    tick();
    tick();
    chk("midrst_err", b_err, 0);

    // Every expected chunk must have been seen.
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
